// File: rtl/cu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | cu_pkg : opcodes, FSM states and control-field codes (rev 1.0)    |
// +-------------------------------------------------------------------+
package cu_pkg;

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_AND  = 7'h02;
  localparam logic [6:0] OP_OR   = 7'h03;
  localparam logic [6:0] OP_ADDI = 7'h04;
  localparam logic [6:0] OP_LW   = 7'h05;
  localparam logic [6:0] OP_SW   = 7'h06;
  localparam logic [6:0] OP_BEQ  = 7'h07;
  localparam logic [6:0] OP_BNE  = 7'h08;
  localparam logic [6:0] OP_BLT  = 7'h09;
  localparam logic [6:0] OP_BGE  = 7'h0A;
  localparam logic [6:0] OP_J    = 7'h0B;
  localparam logic [6:0] OP_JAL  = 7'h0C;
  localparam logic [6:0] OP_JR   = 7'h0D;
  localparam logic [6:0] OP_HALT = 7'h7F;

  typedef enum logic [3:0] {
    S_FETCH1   = 4'd0,
    S_FETCH2   = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD1  = 4'd7,
    S_MEM_RD2  = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BR, C_JMP, C_HALT, C_ILLEGAL
  } instr_class_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_IMM    = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | control_decode : opcode -> class, ALUOp, branchType (rev 1.0)     |
// +-------------------------------------------------------------------+
module control_decode
  import cu_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output instr_class_t o_class,
  output logic [2:0]   o_alu_op,
  output logic [1:0]   o_branch_type,
  output logic         o_is_jal,
  output logic         o_is_jr
);

  always_comb begin
    o_class       = C_ILLEGAL;
    o_alu_op      = ALU_ADD;
    o_branch_type = 2'b00;
    o_is_jal      = 1'b0;
    o_is_jr       = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_class  = C_R;
        o_alu_op = {1'b0, i_opcode[1:0]};
      end
      OP_ADDI: o_class = C_I;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        o_class       = C_BR;
        o_alu_op      = ALU_SUB;
        o_branch_type = 2'(i_opcode - OP_BEQ);
      end
      OP_J:   o_class = C_JMP;
      OP_JAL: begin
        o_class  = C_JMP;
        o_is_jal = 1'b1;
      end
      OP_JR: begin
        o_class = C_JMP;
        o_is_jr = 1'b1;
      end
      OP_HALT: o_class = C_HALT;
      default: o_class = C_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit_fsm.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | control_unit_fsm : multi-cycle main controller, Moore outputs     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module control_unit_fsm
  import cu_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] input_opcode,
  input  logic       input_run,
  output logic       output_PCWrite,
  output logic       output_PC_isbranch,
  output logic [1:0] output_branchType,
  output logic [1:0] output_PCSource,
  output logic       output_IR_write,
  output logic       output_IorD,
  output logic       output_mem_write,
  output logic       output_RegWrite,
  output logic [1:0] output_MemToReg,
  output logic       output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic [2:0] output_ALUOp,
  output logic       output_instr_done,
  output logic       output_halted,
  output logic       output_illegal,
  output logic [3:0] output_state
);

  state_t       r_state;
  state_t       w_next_state;
  logic [6:0]   r_opcode;
  logic [6:0]   w_dec_opcode;
  instr_class_t w_class;
  logic [2:0]   w_alu_op;
  logic [1:0]   w_branch_type;
  logic         w_is_jal;
  logic         w_is_jr;

  // The live field only feeds the DECODE dispatch; no output uses decoded
  // fields in DECODE, so outputs stay a function of state and latched opcode.
  assign w_dec_opcode = (r_state == S_DECODE) ? input_opcode : r_opcode;

  control_decode u_decode (
    .i_opcode      (w_dec_opcode),
    .o_class       (w_class),
    .o_alu_op      (w_alu_op),
    .o_branch_type (w_branch_type),
    .o_is_jal      (w_is_jal),
    .o_is_jr       (w_is_jr)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= RESET_STATE;
      r_opcode <= OP_ADD;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_opcode <= input_opcode;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH1: if (input_run) w_next_state = S_FETCH2;
      S_FETCH2: w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_class)
          C_R:         w_next_state = S_EXEC_R;
          C_I:         w_next_state = S_EXEC_I;
          C_LW, C_SW:  w_next_state = S_MEM_ADDR;
          C_BR:        w_next_state = S_BRANCH;
          C_JMP:       w_next_state = S_JUMP;
          default:     w_next_state = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
      S_MEM_ADDR: w_next_state = (w_class == C_LW) ? S_MEM_RD1 : S_MEM_WR;
      S_MEM_RD1:  w_next_state = S_MEM_RD2;
      S_MEM_RD2:  w_next_state = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: w_next_state = S_FETCH1;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH1;
    endcase
  end

  always_comb begin
    output_PCWrite     = 1'b0;
    output_PC_isbranch = 1'b0;
    output_branchType  = 2'b00;
    output_PCSource    = PCS_ALU;
    output_IR_write    = 1'b0;
    output_IorD        = 1'b0;
    output_mem_write   = 1'b0;
    output_RegWrite    = 1'b0;
    output_MemToReg    = M2R_ALUOUT;
    output_ALUSrcA     = 1'b0;
    output_ALUSrcB     = SRCB_REGB;
    output_ALUOp       = ALU_ADD;
    output_instr_done  = 1'b0;
    output_halted      = 1'b0;
    output_illegal     = 1'b0;
    case (r_state)
      S_FETCH2: begin
        output_IR_write = 1'b1;
        output_ALUSrcB  = SRCB_ONE;
        output_PCWrite  = 1'b1;
      end
      S_DECODE: output_ALUSrcB = SRCB_IMM;
      S_EXEC_R: begin
        output_ALUSrcA = 1'b1;
        output_ALUOp   = w_alu_op;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_IMM;
      end
      S_ALU_WB: begin
        output_RegWrite   = 1'b1;
        output_instr_done = 1'b1;
      end
      S_MEM_RD1, S_MEM_RD2: output_IorD = 1'b1;
      S_MEM_WB: begin
        output_RegWrite   = 1'b1;
        output_MemToReg   = M2R_MDR;
        output_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        output_IorD       = 1'b1;
        output_mem_write  = 1'b1;
        output_instr_done = 1'b1;
      end
      S_BRANCH: begin
        output_ALUSrcA     = 1'b1;
        output_ALUOp       = w_alu_op;
        output_PC_isbranch = 1'b1;
        output_PCSource    = PCS_ALUOUT;
        output_branchType  = w_branch_type;
        output_instr_done  = 1'b1;
      end
      S_JUMP: begin
        output_PCWrite    = 1'b1;
        output_PCSource   = w_is_jr ? PCS_REGA : PCS_IMM;
        output_RegWrite   = w_is_jal;
        output_MemToReg   = w_is_jal ? M2R_PC : M2R_ALUOUT;
        output_instr_done = 1'b1;
      end
      S_HALT: begin
        output_halted  = 1'b1;
        output_illegal = (w_class == C_ILLEGAL);
      end
      default: ;
    endcase
  end

  assign output_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_control_unit_fsm : directed + randomized checks of the FSM     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_control_unit_fsm;
  import cu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [6:0] input_opcode = 7'h00;
  logic       input_run = 1'b0;
  logic       output_PCWrite, output_PC_isbranch, output_IR_write, output_IorD;
  logic       output_mem_write, output_RegWrite, output_ALUSrcA, output_instr_done;
  logic       output_halted, output_illegal;
  logic [1:0] output_branchType, output_PCSource, output_MemToReg, output_ALUSrcB;
  logic [2:0] output_ALUOp;
  logic [3:0] output_state;

  control_unit_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .input_opcode(input_opcode), .input_run(input_run),
    .output_PCWrite(output_PCWrite), .output_PC_isbranch(output_PC_isbranch),
    .output_branchType(output_branchType), .output_PCSource(output_PCSource),
    .output_IR_write(output_IR_write), .output_IorD(output_IorD),
    .output_mem_write(output_mem_write), .output_RegWrite(output_RegWrite),
    .output_MemToReg(output_MemToReg), .output_ALUSrcA(output_ALUSrcA),
    .output_ALUSrcB(output_ALUSrcB), .output_ALUOp(output_ALUOp),
    .output_instr_done(output_instr_done), .output_halted(output_halted),
    .output_illegal(output_illegal), .output_state(output_state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, isbr;
    logic [1:0] bt, pcs;
    logic       ir, iord, memw, regw;
    logic [1:0] m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       done, halt, ill;
  } obs_t;

  obs_t tr [0:31];
  int   tr_len;
  int   errors = 0;
  int   checks = 0;
  int   mem_writes = 0;

  // Memory-side view: a write happens when the enable is high at a clock edge.
  always @(posedge CLK) if (output_mem_write) mem_writes <= mem_writes + 1;

  function automatic obs_t sample();
    obs_t o;
    o.st = output_state;  o.pcw = output_PCWrite;  o.isbr = output_PC_isbranch;
    o.bt = output_branchType;  o.pcs = output_PCSource;  o.ir = output_IR_write;
    o.iord = output_IorD;  o.memw = output_mem_write;  o.regw = output_RegWrite;
    o.m2r = output_MemToReg;  o.srca = output_ALUSrcA;  o.srcb = output_ALUSrcB;
    o.aluop = output_ALUOp;  o.done = output_instr_done;
    o.halt = output_halted;  o.ill = output_illegal;
    return o;
  endfunction

  function automatic logic any_en();
    return output_PCWrite | output_PC_isbranch | output_IR_write |
           output_mem_write | output_RegWrite;
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    input_run = 1'b0;
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    step();
  endtask

  // Runs one instruction from FETCH1; trace index 1 is the FETCH1 cycle.
  // After DECODE the IR field is scrambled so only the latched copy matters.
  task automatic run_instr(input logic [6:0] op);
    int   cyc;
    bit   fin;
    logic was_dec;
    input_opcode = op;
    input_run    = 1'b1;
    cyc = 0; fin = 0; tr_len = 0;
    while (!fin && cyc < 16) begin
      cyc++;
      tr[cyc] = sample();
      tr_len  = cyc;
      if (output_instr_done || output_halted) fin = 1;
      else begin
        was_dec = (output_state == S_DECODE);
        step();
        if (was_dec) input_opcode = 7'($urandom);
      end
    end
    if (!output_halted) step();
  endtask

  // Reference: expected behaviour of one instruction from the opcode table.
  function automatic void model(input logic [6:0] op, output int lat, output int n_reg,
                                output int n_mem, output int n_pcw, output int n_done,
                                output int last_en, output logic [1:0] m2r,
                                output logic [1:0] pcs, output logic halt, output logic ill);
    n_reg = 0; n_mem = 0; n_pcw = 1; n_done = 1; m2r = 2'd0; pcs = 2'd0;
    halt = 1'b0; ill = 1'b0;
    if (op <= 7'h04)      begin lat = 5; n_reg = 1; end
    else if (op == 7'h05) begin lat = 7; n_reg = 1; m2r = 2'd1; end
    else if (op == 7'h06) begin lat = 5; n_mem = 1; end
    else if (op <= 7'h0A) begin lat = 4; pcs = 2'd1; end
    else if (op <= 7'h0D) begin
      lat = 4; n_pcw = 2;
      pcs = (op == 7'h0D) ? 2'd3 : 2'd2;
      if (op == 7'h0C) begin n_reg = 1; m2r = 2'd2; end
    end else begin
      // Three cycles to reach HALT; the trace records the first halted cycle.
      lat = 4; halt = 1'b1; ill = (op != 7'h7F); n_done = 0;
    end
    last_en = halt ? 2 : lat;
  endfunction

  task automatic test_reset();
    input_run = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (output_state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", output_state);
    end
    checks++;
    if (any_en() !== 1'b0 || output_instr_done !== 1'b0) begin
      errors++; $display("FAIL reset_enables: got en=%b done=%b want 0", any_en(), output_instr_done);
    end
    checks++;
    if (output_halted !== 1'b0 || output_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got halted=%b illegal=%b want 0 0", output_halted, output_illegal);
    end
    @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (output_state !== S_FETCH1 || any_en() !== 1'b0) begin
        errors++; $display("FAIL idle_hold cycle %0d: got state=%0d en=%b want FETCH1 en=0", i, output_state, any_en());
      end
    end
    input_run = 1'b1;
    step();
    checks++;
    if (output_state !== S_FETCH2 || output_IR_write !== 1'b1 || output_PCWrite !== 1'b1) begin
      errors++; $display("FAIL run_start: got state=%0d ir=%b pcw=%b want FETCH2 1 1", output_state, output_IR_write, output_PCWrite);
    end
    do_reset();
  endtask

  task automatic test_rtype();
    run_instr(OP_ADD);
    checks++;
    if (tr_len !== 5 || tr[5].done !== 1'b1) begin
      errors++; $display("FAIL add_latency: got %0d want 5", tr_len);
    end
    checks++;
    if (tr[4].st !== S_EXEC_R || tr[4].aluop !== 3'b000 || tr[4].srca !== 1'b1 || tr[4].srcb !== 2'd0) begin
      errors++; $display("FAIL add_exec: got st=%0d op=%b a=%b b=%0d want EXEC_R 000 1 0", tr[4].st, tr[4].aluop, tr[4].srca, tr[4].srcb);
    end
    checks++;
    if (tr[5].regw !== 1'b1 || tr[5].m2r !== 2'd0) begin
      errors++; $display("FAIL add_wb: got regw=%b m2r=%0d want 1 0", tr[5].regw, tr[5].m2r);
    end
    run_instr(OP_SUB);
    checks++;
    if (tr_len !== 5 || tr[5].done !== 1'b1) begin
      errors++; $display("FAIL sub_latency: got %0d want 5", tr_len);
    end
    checks++;
    if (tr[4].aluop !== 3'b001) begin
      errors++; $display("FAIL sub_aluop: got %b want 001", tr[4].aluop);
    end
  endtask

  task automatic test_mem();
    int w0, sumreg, summem;
    run_instr(OP_LW);
    checks++;
    if (tr_len !== 7 || tr[7].done !== 1'b1 || tr[7].regw !== 1'b1 || tr[7].m2r !== 2'd1) begin
      errors++; $display("FAIL lw_wb: got len=%0d regw=%b m2r=%0d want 7 1 1", tr_len, tr[7].regw, tr[7].m2r);
    end
    checks++;
    if (tr[5].iord !== 1'b1 || tr[6].iord !== 1'b1) begin
      errors++; $display("FAIL lw_iord: got %b%b want 11", tr[5].iord, tr[6].iord);
    end
    w0 = mem_writes;
    run_instr(OP_SW);
    sumreg = 0; summem = 0;
    for (int i = 1; i <= tr_len; i++) begin
      sumreg += int'(tr[i].regw);
      summem += int'(tr[i].memw);
    end
    checks++;
    if (tr_len !== 5 || tr[5].memw !== 1'b1 || tr[5].iord !== 1'b1 || summem != 1) begin
      errors++; $display("FAIL sw_write: got len=%0d memw5=%b count=%0d want 5 1 1", tr_len, tr[5].memw, summem);
    end
    checks++;
    if (sumreg != 0 || mem_writes - w0 != 1) begin
      errors++; $display("FAIL sw_side: got regw=%0d memwrites=%0d want 0 1", sumreg, mem_writes - w0);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(OP_BLT);
    checks++;
    if (tr_len !== 4 || tr[4].isbr !== 1'b1 || tr[4].bt !== 2'b10 || tr[4].aluop !== 3'b001 ||
        tr[4].pcs !== 2'd1 || tr[4].pcw !== 1'b0 || tr[4].done !== 1'b1) begin
      errors++; $display("FAIL blt: got len=%0d br=%b bt=%b op=%b pcs=%0d pcw=%b want 4 1 10 001 1 0",
                         tr_len, tr[4].isbr, tr[4].bt, tr[4].aluop, tr[4].pcs, tr[4].pcw);
    end
    run_instr(OP_JAL);
    checks++;
    if (tr_len !== 4 || tr[4].pcw !== 1'b1 || tr[4].pcs !== 2'd2 || tr[4].regw !== 1'b1 || tr[4].m2r !== 2'd2) begin
      errors++; $display("FAIL jal: got len=%0d pcw=%b pcs=%0d regw=%b m2r=%0d want 4 1 2 1 2",
                         tr_len, tr[4].pcw, tr[4].pcs, tr[4].regw, tr[4].m2r);
    end
    run_instr(OP_JR);
    checks++;
    if (tr[4].pcw !== 1'b1 || tr[4].pcs !== 2'd3 || tr[4].regw !== 1'b0) begin
      errors++; $display("FAIL jr: got pcw=%b pcs=%0d regw=%b want 1 3 0", tr[4].pcw, tr[4].pcs, tr[4].regw);
    end
  endtask

  task automatic test_halt();
    int bad;
    run_instr(7'h55);
    checks++;
    if (tr_len !== 4 || tr[4].st !== S_HALT || tr[4].halt !== 1'b1 || tr[4].ill !== 1'b1) begin
      errors++; $display("FAIL illegal_entry: got len=%0d st=%0d h=%b i=%b want 4 HALT 1 1", tr_len, tr[4].st, tr[4].halt, tr[4].ill);
    end
    bad = 0;
    for (int i = 1; i <= tr_len; i++) if (tr[i].done || tr[i].regw || tr[i].memw) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL illegal_writes: got %0d cycles with writes/done want 0", bad);
    end
    input_run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      input_opcode = 7'($urandom);
      step();
      checks++;
      if (output_state !== S_HALT || output_halted !== 1'b1 || any_en() !== 1'b0 || output_instr_done !== 1'b0) begin
        errors++; $display("FAIL halt_hold cycle %0d: got st=%0d h=%b en=%b want HALT 1 0", i, output_state, output_halted, any_en());
      end
    end
    do_reset();
    checks++;
    if (output_halted !== 1'b0 || output_illegal !== 1'b0 || output_state !== S_FETCH1) begin
      errors++; $display("FAIL halt_exit: got h=%b i=%b st=%0d want 0 0 0", output_halted, output_illegal, output_state);
    end
    run_instr(OP_HALT);
    checks++;
    if (tr_len !== 4 || tr[4].halt !== 1'b1 || tr[4].ill !== 1'b0) begin
      errors++; $display("FAIL halt_op: got len=%0d h=%b i=%b want 4 1 0", tr_len, tr[4].halt, tr[4].ill);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    int n, w0;
    input_opcode = OP_SW;
    input_run    = 1'b1;
    n = 0;
    while (output_state !== S_MEM_WR && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (output_state !== S_MEM_WR || output_mem_write !== 1'b1) begin
      errors++; $display("FAIL async_reach: got st=%0d memw=%b want MEM_WR 1", output_state, output_mem_write);
    end
    w0 = mem_writes;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (output_mem_write !== 1'b0 || output_state !== S_FETCH1) begin
      errors++; $display("FAIL async_drop: got memw=%b st=%0d want 0 0", output_mem_write, output_state);
    end
    step();
    checks++;
    if (mem_writes != w0) begin
      errors++; $display("FAIL async_nowrite: got %0d writes want 0", mem_writes - w0);
    end
    input_run = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    step();
  endtask

  task automatic test_random();
    int r, k, lat, n_reg, n_mem, n_pcw, n_done, last_en;
    int o_reg, o_mem, o_pcw, o_done, o_last;
    logic [1:0] m2r, pcs;
    logic halt, ill;
    logic [6:0] op;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 19);
      if (r <= 13)      op = 7'(r);
      else if (r == 14) op = 7'h7F;
      else if (r == 15) op = 7'($urandom_range(14, 126));
      else              op = 7'($urandom_range(0, 13));
      k = $urandom_range(0, 3);
      input_run = 1'b0;
      for (int j = 0; j < k; j++) step();
      checks++;
      if (output_state !== S_FETCH1) begin
        errors++; $display("FAIL rnd_idle it=%0d: got st=%0d want FETCH1", it, output_state);
      end
      run_instr(op);
      model(op, lat, n_reg, n_mem, n_pcw, n_done, last_en, m2r, pcs, halt, ill);
      o_reg = 0; o_mem = 0; o_pcw = 0; o_done = 0; o_last = 0;
      for (int i = 1; i <= tr_len; i++) begin
        o_reg  += int'(tr[i].regw);
        o_mem  += int'(tr[i].memw);
        o_pcw  += int'(tr[i].pcw);
        o_done += int'(tr[i].done);
        if (tr[i].regw || tr[i].memw || tr[i].pcw || tr[i].isbr) o_last = i;
      end
      checks++;
      if (tr_len != lat) begin
        errors++; $display("FAIL rnd_latency op=%h: got %0d want %0d", op, tr_len, lat);
      end
      checks++;
      if (o_reg != n_reg || o_mem != n_mem || o_pcw != n_pcw || o_done != n_done) begin
        errors++; $display("FAIL rnd_counts op=%h: got reg=%0d mem=%0d pcw=%0d done=%0d want %0d %0d %0d %0d",
                           op, o_reg, o_mem, o_pcw, o_done, n_reg, n_mem, n_pcw, n_done);
      end
      checks++;
      if (o_last != last_en) begin
        errors++; $display("FAIL rnd_last_enable op=%h: got cycle %0d want %0d", op, o_last, last_en);
      end
      checks++;
      if (tr[tr_len].m2r !== m2r || tr[tr_len].pcs !== pcs ||
          tr[tr_len].halt !== halt || tr[tr_len].ill !== ill) begin
        errors++; $display("FAIL rnd_final op=%h: got m2r=%0d pcs=%0d h=%b i=%b want %0d %0d %b %b",
                           op, tr[tr_len].m2r, tr[tr_len].pcs, tr[tr_len].halt, tr[tr_len].ill, m2r, pcs, halt, ill);
      end
      if (output_halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_halt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
